// File: rtl/risc16_mc_core.sv
// Multicycle RiSC-16 core: FETCH/EXEC/MEM/HALT sequencer sharing one req/ready
// memory port for instructions and data, with halt-JALR and cycle/retire counters.
module risc16_mc_core #(
   parameter logic [15:0] RESET_PC = 16'h0000,
   parameter int unsigned CNT_W    = 32,
   parameter bit          HALT_EN  = 1'b1
) (
   input  logic             clk,
   input  logic             reset_n,
   output logic             mem_req,
   output logic             mem_we,
   output logic [15:0]      mem_addr,
   output logic [15:0]      mem_wdata,
   input  logic             mem_ready,
   input  logic [15:0]      mem_rdata,
   output logic [15:0]      curr_pc,
   output logic [15:0]      curr_instr,
   output logic             retire,
   output logic             halted,
   output logic [CNT_W-1:0] cycle_cnt,
   output logic [CNT_W-1:0] instret_cnt
);

   localparam logic [2:0] OP_ADD  = 3'd0;
   localparam logic [2:0] OP_ADDI = 3'd1;
   localparam logic [2:0] OP_NAND = 3'd2;
   localparam logic [2:0] OP_LUI  = 3'd3;
   localparam logic [2:0] OP_SW   = 3'd4;
   localparam logic [2:0] OP_LW   = 3'd5;
   localparam logic [2:0] OP_BEQ  = 3'd6;
   localparam logic [2:0] OP_JALR = 3'd7;

   typedef enum logic [1:0] {FETCH, EXEC, MEM, HALT} state_t;

   state_t           state_q;
   logic [15:0]      pc_q;
   logic [15:0]      instr_q;
   logic [15:0]      rf_q [8];
   logic             mem_req_q;
   logic             retire_q;
   logic             halted_q;
   logic [CNT_W-1:0] cycle_q;
   logic [CNT_W-1:0] instret_q;

   logic [2:0]  op, ra, rb, rc, portXAddr;
   logic [15:0] simm, rdX, rdB, pcPlus1, effAddr, aluResult, nextPc;
   logic        writesReg, isHalt, isMemOp, cntEn;

   assign op      = instr_q[15:13];
   assign ra      = instr_q[12:10];
   assign rb      = instr_q[9:7];
   assign rc      = instr_q[2:0];
   assign simm    = {{9{instr_q[6]}}, instr_q[6:0]};
   assign pcPlus1 = pc_q + 16'd1;

   // Port X reads rC for the register-register ops and rA for everything else
   assign portXAddr = (op == OP_ADD || op == OP_NAND) ? rc : ra;
   assign rdX       = (portXAddr == 3'd0) ? 16'h0000 : rf_q[portXAddr];
   assign rdB       = (rb == 3'd0) ? 16'h0000 : rf_q[rb];
   assign effAddr   = rdB + simm;

   assign isMemOp = (op == OP_SW) || (op == OP_LW);
   assign isHalt  = HALT_EN && (op == OP_JALR) && (instr_q[6:0] != 7'd0);

   always_comb begin
      aluResult = pcPlus1;
      nextPc    = pcPlus1;
      writesReg = 1'b0;
      case (op)
         OP_ADD:  begin aluResult = rdB + rdX;             writesReg = 1'b1; end
         OP_ADDI: begin aluResult = rdB + simm;            writesReg = 1'b1; end
         OP_NAND: begin aluResult = ~(rdB & rdX);          writesReg = 1'b1; end
         OP_LUI:  begin aluResult = {instr_q[9:0], 6'b0};  writesReg = 1'b1; end
         OP_BEQ:  if (rdX == rdB) nextPc = pcPlus1 + simm;
         OP_JALR: begin nextPc = rdB;                      writesReg = 1'b1; end
         default: ;
      endcase
   end

   // The idle FETCH cycle right after reset release is not counted
   assign cntEn = (state_q != HALT) && !(state_q == FETCH && !mem_req_q);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= FETCH;
         pc_q      <= RESET_PC;
         instr_q   <= 16'h0000;
         mem_req_q <= 1'b0;
         retire_q  <= 1'b0;
         halted_q  <= 1'b0;
         cycle_q   <= '0;
         instret_q <= '0;
         for (int i = 0; i < 8; i++) rf_q[i] <= 16'h0000;
      end else begin
         retire_q <= 1'b0;
         if (cntEn) cycle_q <= cycle_q + CNT_W'(1);
         case (state_q)
            FETCH: begin
               if (!mem_req_q) begin
                  mem_req_q <= 1'b1;
               end else if (mem_ready) begin
                  instr_q   <= mem_rdata;
                  mem_req_q <= 1'b0;
                  state_q   <= EXEC;
               end
            end
            EXEC: begin
               if (isMemOp) begin
                  mem_req_q <= 1'b1;
                  state_q   <= MEM;
               end else if (isHalt) begin
                  retire_q  <= 1'b1;
                  instret_q <= instret_q + CNT_W'(1);
                  halted_q  <= 1'b1;
                  state_q   <= HALT;
               end else begin
                  if (writesReg && ra != 3'd0) rf_q[ra] <= aluResult;
                  pc_q      <= nextPc;
                  retire_q  <= 1'b1;
                  instret_q <= instret_q + CNT_W'(1);
                  mem_req_q <= 1'b1;
                  state_q   <= FETCH;
               end
            end
            MEM: begin
               if (mem_ready) begin
                  if (op == OP_LW && ra != 3'd0) rf_q[ra] <= mem_rdata;
                  pc_q      <= pcPlus1;
                  retire_q  <= 1'b1;
                  instret_q <= instret_q + CNT_W'(1);
                  state_q   <= FETCH;
               end
            end
            HALT: mem_req_q <= 1'b0;
            default: state_q <= FETCH;
         endcase
      end
   end

   assign mem_req     = mem_req_q;
   assign mem_we      = (state_q == MEM) && (op == OP_SW);
   assign mem_addr    = (state_q == MEM) ? effAddr : pc_q;
   assign mem_wdata   = rdX;
   assign curr_pc     = pc_q;
   assign curr_instr  = instr_q;
   assign retire      = retire_q;
   assign halted      = halted_q;
   assign cycle_cnt   = cycle_q;
   assign instret_cnt = instret_q;

endmodule

// File: tb/tb_risc16_mc_core.sv
// Bench for risc16_mc_core: wait-state memory, an instruction-level ISS that predicts
// every memory transfer and counter value, and directed programs with literal results.
module tb_risc16_mc_core;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        mem_ready = 1'b0;
   logic [15:0] mem_rdata = 16'h0000;
   logic        mem_req, mem_we, retire, halted;
   logic [15:0] mem_addr, mem_wdata, curr_pc, curr_instr;
   logic [31:0] cycle_cnt, instret_cnt;

   risc16_mc_core #(.RESET_PC(16'h0000), .CNT_W(32), .HALT_EN(1'b1)) dut (
      .clk(clk), .reset_n(reset_n),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ready(mem_ready), .mem_rdata(mem_rdata),
      .curr_pc(curr_pc), .curr_instr(curr_instr), .retire(retire), .halted(halted),
      .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic [15:0] mem [256];
   int          waitCycles = 0;

   // Architectural model: registers, PC, phase 0=fetch 1=data 2=halted
   logic [15:0] R [8];
   logic [15:0] mPc = 16'h0000;
   logic [15:0] mInstr = 16'h0000;
   int          mPhase = 0;
   int          mRetired = 0;
   int          benchCycles = 0;
   int          retireSeen = 0;
   bit          started = 1'b0, frozen = 1'b0, haltPending = 1'b0;

   bit          inTxn = 1'b0;
   logic [15:0] txnAddr, txnWdata, respData;
   logic        txnWe;
   int          waitCnt = 0;

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
      end
   endtask

   function automatic logic [15:0] sext7(input logic [6:0] v);
      return {{9{v[6]}}, v};
   endfunction

   function automatic logic [15:0] rri(input logic [2:0] op, input logic [2:0] a, input logic [2:0] b, input int imm);
      logic [6:0] i7;
      i7 = imm[6:0];
      return {op, a, b, i7};
   endfunction

   function automatic logic [15:0] rrr(input logic [2:0] op, input logic [2:0] a, input logic [2:0] b, input logic [2:0] c);
      return {op, a, b, 4'b0000, c};
   endfunction

   function automatic logic [15:0] lui(input logic [2:0] a, input logic [9:0] imm10);
      return {3'd3, a, imm10};
   endfunction

   localparam logic [15:0] HALT_W = 16'hE001;

   task automatic modelWrite(input logic [2:0] a, input logic [15:0] v);
      if (a != 3'd0) R[a] = v;
   endtask

   task automatic modelCommit(input logic [15:0] data);
      logic [2:0]  op, a, b, c;
      logic [15:0] s, link, target;
      if (mPhase == 0) mInstr = data;
      op = mInstr[15:13]; a = mInstr[12:10]; b = mInstr[9:7]; c = mInstr[2:0];
      s  = sext7(mInstr[6:0]);
      if (mPhase == 1) begin
         if (op == 3'd5) modelWrite(a, data);
         mPc = mPc + 16'd1;
         mRetired++;
         mPhase = 0;
      end else if (mPhase == 0) begin
         case (op)
            3'd0: begin modelWrite(a, R[b] + R[c]);      mPc = mPc + 16'd1; mRetired++; end
            3'd1: begin modelWrite(a, R[b] + s);         mPc = mPc + 16'd1; mRetired++; end
            3'd2: begin modelWrite(a, ~(R[b] & R[c]));   mPc = mPc + 16'd1; mRetired++; end
            3'd3: begin modelWrite(a, {mInstr[9:0], 6'b0}); mPc = mPc + 16'd1; mRetired++; end
            3'd4, 3'd5: mPhase = 1;
            3'd6: begin
               mPc = (R[a] == R[b]) ? mPc + 16'd1 + s : mPc + 16'd1;
               mRetired++;
            end
            default: begin
               if (mInstr[6:0] != 7'd0) begin
                  haltPending = 1'b1;
                  mPhase = 2;
               end else begin
                  link = mPc + 16'd1; target = R[b];
                  modelWrite(a, link);
                  mPc = target;
               end
               mRetired++;
            end
         endcase
      end
   endtask

   task automatic resetModel();
      for (int i = 0; i < 8; i++) R[i] = 16'h0000;
      mPc = 16'h0000; mInstr = 16'h0000; mPhase = 0; mRetired = 0;
      benchCycles = 0; retireSeen = 0; started = 1'b0; frozen = 1'b0; haltPending = 1'b0;
      inTxn = 1'b0; waitCnt = 0; mem_ready = 1'b0;
   endtask

   // Memory responder and per-cycle compare against the model
   initial forever begin
      @(negedge clk);
      if (!reset_n) begin
         mem_ready = 1'b0; inTxn = 1'b0; waitCnt = 0;
      end else begin
         if (retire) retireSeen++;
         checkOutput("instret_vs_retire", instret_cnt, retireSeen);
         checkOutput("cycle_cnt", cycle_cnt, benchCycles);
         checkOutput("halted", halted, frozen);
         if (mem_req) begin
            if (!inTxn) begin
               inTxn = 1'b1; waitCnt = 0;
               txnAddr = mem_addr; txnWe = mem_we; txnWdata = mem_wdata;
               checkOutput("instret_at_txn", instret_cnt, mRetired);
               if (mPhase == 0) begin
                  checkOutput("fetch_addr", mem_addr, mPc);
                  checkOutput("fetch_we", mem_we, 1'b0);
               end else if (mPhase == 1) begin
                  checkOutput("data_addr", mem_addr, R[mInstr[9:7]] + sext7(mInstr[6:0]));
                  checkOutput("data_we", mem_we, mInstr[15:13] == 3'd4);
                  if (mInstr[15:13] == 3'd4) checkOutput("data_wdata", mem_wdata, R[mInstr[12:10]]);
               end else begin
                  checkOutput("req_after_halt", mem_req, 1'b0);
               end
            end else begin
               checkOutput("stable_addr", mem_addr, txnAddr);
               checkOutput("stable_we", mem_we, txnWe);
               if (txnWe) checkOutput("stable_wdata", mem_wdata, txnWdata);
            end
            if (waitCnt >= waitCycles) begin
               mem_ready = 1'b1;
               mem_rdata = mem[mem_addr[7:0]];
               respData  = mem_rdata;
            end else begin
               mem_ready = 1'b0;
               mem_rdata = 16'hDEAD;
               waitCnt++;
            end
         end else begin
            if (inTxn) checkOutput("req_held", mem_req, 1'b1);
            mem_ready = 1'b0;
         end
      end
   end

   // Transfer completion and the bench's own cycle count
   initial forever begin
      @(posedge clk);
      if (reset_n) begin
         if (!started) started = 1'b1;
         else if (!frozen) begin
            benchCycles++;
            if (haltPending) frozen = 1'b1;
         end
         if (inTxn && mem_ready) begin
            if (txnWe) mem[txnAddr[7:0]] = txnWdata;
            inTxn = 1'b0;
            modelCommit(respData);
         end
      end
   end

   task automatic clearMem();
      for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
   endtask

   task automatic applyStimulus(input int waits);
      @(negedge clk);
      reset_n = 1'b0;
      resetModel();
      waitCycles = waits;
      repeat (2) @(negedge clk);
      checkOutput("rst_pc", curr_pc, 16'h0000);
      checkOutput("rst_instr", curr_instr, 16'h0000);
      checkOutput("rst_req", mem_req, 1'b0);
      checkOutput("rst_retire", retire, 1'b0);
      checkOutput("rst_halted", halted, 1'b0);
      checkOutput("rst_cycle", cycle_cnt, 0);
      checkOutput("rst_instret", instret_cnt, 0);
      reset_n = 1'b1;
   endtask

   task automatic runToHalt(input int budget);
      int n;
      n = 0;
      while (!halted && n < budget) begin
         @(negedge clk);
         n++;
      end
      checkOutput("halt_reached", halted, 1'b1);
      repeat (3) @(negedge clk);
      checkOutput("model_done", mPhase, 2);
   endtask

   initial begin
      #300000;
      $display("[TB] FAIL watchdog expired actual=running expected=finished");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int n;
      resetModel();

      // Program A: ALU sequence, zero wait states
      clearMem();
      mem[0] = rri(3'd1, 3'd1, 3'd0, 5);
      mem[1] = rri(3'd1, 3'd2, 3'd0, -3);
      mem[2] = rrr(3'd0, 3'd3, 3'd1, 3'd2);
      mem[3] = rrr(3'd2, 3'd4, 3'd1, 3'd1);
      mem[4] = HALT_W;
      applyStimulus(0);
      runToHalt(200);
      checkOutput("A_instret", instret_cnt, 5);
      checkOutput("A_cycle", cycle_cnt, 10);
      checkOutput("A_halted", halted, 1'b1);
      checkOutput("A_pc", curr_pc, 16'h0004);
      checkOutput("A_instr", curr_instr, HALT_W);
      checkOutput("A_model_r3", R[3], 16'h0002);
      checkOutput("A_model_r4", R[4], 16'hFFFA);

      // Program B: LUI/ADDI, r0 write, SW/LW round trip with 3 wait states
      clearMem();
      mem[0] = lui(3'd1, 10'h2AF);
      mem[1] = rri(3'd1, 3'd1, 3'd1, 13);
      mem[2] = rri(3'd1, 3'd0, 3'd0, 7);
      mem[3] = rri(3'd4, 3'd1, 3'd0, 20);
      mem[4] = rri(3'd5, 3'd2, 3'd0, 20);
      mem[5] = rri(3'd4, 3'd2, 3'd0, 21);
      mem[6] = rri(3'd4, 3'd0, 3'd0, 22);
      mem[7] = HALT_W;
      mem[22] = 16'h1234;
      applyStimulus(3);
      runToHalt(400);
      checkOutput("B_mem20", mem[20], 16'hABCD);
      checkOutput("B_mem21_lw", mem[21], 16'hABCD);
      checkOutput("B_mem22_r0", mem[22], 16'h0000);
      checkOutput("B_instret", instret_cnt, 8);
      checkOutput("B_cycle", cycle_cnt, 56);
      checkOutput("B_model_r2", R[2], 16'hABCD);

      // Program C: countdown loop, BEQ both ways, JALR from 0x10 to 0x40
      clearMem();
      mem[0]  = rri(3'd1, 3'd1, 3'd0, 3);
      mem[1]  = rri(3'd1, 3'd1, 3'd1, -1);
      mem[2]  = rri(3'd6, 3'd1, 3'd0, 1);
      mem[3]  = rri(3'd6, 3'd0, 3'd0, -3);
      mem[4]  = rri(3'd4, 3'd1, 3'd0, 50);
      mem[5]  = lui(3'd5, 10'd1);
      mem[6]  = rri(3'd6, 3'd0, 3'd0, 9);
      mem[16] = rri(3'd7, 3'd7, 3'd5, 0);
      mem[64] = rri(3'd4, 3'd7, 3'd0, 51);
      mem[65] = HALT_W;
      mem[50] = 16'hFFFF;
      applyStimulus(0);
      runToHalt(400);
      checkOutput("C_r1_zero", mem[50], 16'h0000);
      checkOutput("C_link", mem[51], 16'h0011);
      checkOutput("C_instret", instret_cnt, 15);
      checkOutput("C_cycle", cycle_cnt, 32);
      checkOutput("C_pc", curr_pc, 16'h0041);
      checkOutput("C_model_retired", mRetired, 15);

      // Program D: reset pulsed during the data phase of a SW
      clearMem();
      mem[0]  = rri(3'd1, 3'd1, 3'd0, 9);
      mem[1]  = rri(3'd4, 3'd1, 3'd0, 60);
      mem[2]  = HALT_W;
      mem[60] = 16'h5555;
      applyStimulus(3);
      n = 0;
      while (!(mem_req && mem_we) && n < 100) begin
         @(negedge clk);
         n++;
      end
      checkOutput("D_reached_sw", mem_req && mem_we, 1'b1);
      #2;
      reset_n = 1'b0;
      #1;
      checkOutput("D_req_async", mem_req, 1'b0);
      resetModel();
      checkOutput("D_cycle_rst", cycle_cnt, 0);
      checkOutput("D_instret_rst", instret_cnt, 0);
      checkOutput("D_pc_rst", curr_pc, 16'h0000);
      repeat (2) @(negedge clk);
      checkOutput("D_no_write", mem[60], 16'h5555);
      reset_n = 1'b1;
      runToHalt(400);
      checkOutput("D_mem60", mem[60], 16'h0009);
      checkOutput("D_instret", instret_cnt, 3);
      checkOutput("D_cycle", cycle_cnt, 19);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
